// File: rtl/tcam_pkg.sv
// tcam_pkg: default TCAM geometry and a constant-foldable clog2 shared by RTL and bench
package tcam_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF = 20;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/tcam_prio_enc.sv
// tcam_prio_enc: combinational lowest-index-wins priority encoder
module tcam_prio_enc
  import tcam_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  vec,
  output logic              hit,
  output logic [ADDR_W-1:0] idx
);
  always_comb begin
    hit = |vec;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (vec[i]) idx = ADDR_W'(i);
  end
endmodule

// File: rtl/tcam_prio_search.sv
// tcam_prio_search: ternary CAM with valid bits, invalidate/flush, occupancy count
// and a two-stage search pipeline ending in a lowest-index priority result.
module tcam_prio_search
  import tcam_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = clog2(DEPTH),
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic              flush,
  input  logic              srch_en,
  input  logic [DATA_W-1:0] srch_key,
  output logic [DEPTH-1:0]  matched,
  output logic              rslt_valid,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_idx,
  output logic [CNT_W-1:0]  num_valid
);
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DATA_W-1:0] mask_q [DEPTH];
  logic [DATA_W-1:0] mask_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d, key_vec, s1_vec_q, s1_vec_d, matched_q, matched_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d, enc_idx;
  logic              s1_vld_q, s1_vld_d, rv_q, rv_d, hit_q, hit_d, enc_hit, wr_ok, inv_ok;

  tcam_prio_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_enc (
    .vec(s1_vec_q),
    .hit(enc_hit),
    .idx(enc_idx)
  );

  always_comb begin
    wr_ok = wr_en && (int'(wr_addr) < DEPTH);
    inv_ok = inv_en && (int'(inv_addr) < DEPTH);
    key_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      key_vec[i] = valid_q[i] && (((srch_key ^ data_q[i]) & mask_q[i]) == '0);
    data_d = data_q;
    mask_d = mask_q;
    valid_d = valid_q;
    // invalidate applied before write so a same-address write leaves the entry valid
    if (flush) valid_d = '0;
    else begin
      if (inv_ok) valid_d[inv_addr] = 1'b0;
      if (wr_ok) begin
        valid_d[wr_addr] = 1'b1;
        data_d[wr_addr] = wr_data;
        mask_d[wr_addr] = wr_mask;
      end
    end
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(valid_d[i]);
    s1_vld_d = srch_en;
    s1_vec_d = srch_en ? key_vec : s1_vec_q;
    rv_d = s1_vld_q;
    matched_d = s1_vld_q ? s1_vec_q : matched_q;
    hit_d = s1_vld_q ? enc_hit : hit_q;
    idx_d = s1_vld_q ? enc_idx : idx_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '{default: '0};
      mask_q <= '{default: '0};
      valid_q <= '0;
      cnt_q <= '0;
      s1_vld_q <= 1'b0;
      s1_vec_q <= '0;
      rv_q <= 1'b0;
      matched_q <= '0;
      hit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      s1_vld_q <= s1_vld_d;
      s1_vec_q <= s1_vec_d;
      rv_q <= rv_d;
      matched_q <= matched_d;
      hit_q <= hit_d;
      idx_q <= idx_d;
    end
  end

  assign matched = matched_q;
  assign rslt_valid = rv_q;
  assign hit = hit_q;
  assign hit_idx = idx_q;
  assign num_valid = cnt_q;
endmodule

// File: tb/tb_tcam_prio_search.sv
// tb_tcam_prio_search: directed steps with a behavioural TCAM model feeding a result scoreboard
module tb_tcam_prio_search;
  import tcam_pkg::*;
  localparam int DW = DATA_W_DEF;
  localparam int DP = DEPTH_DEF;
  localparam int AW = clog2(DP);
  localparam int CW = clog2(DP + 1);

  typedef struct packed {
    logic [DP-1:0] m;
    logic          h;
    logic [AW-1:0] i;
  } rslt_t;

  logic          clk = 0, reset = 0;
  logic          wr_en = 0, inv_en = 0, flush = 0, srch_en = 0;
  logic [AW-1:0] wr_addr = 0, inv_addr = 0, hit_idx;
  logic [DW-1:0] wr_data = 0, wr_mask = 0, srch_key = 0;
  logic [DP-1:0] matched;
  logic          rslt_valid, hit;
  logic [CW-1:0] num_valid;

  rslt_t         exp_q[$];
  logic [DW-1:0] md[DP];
  logic [DW-1:0] mm[DP];
  logic [DP-1:0] mv = '0;
  int            mcnt = 0;
  int            n_cmp = 0, n_err = 0;

  tcam_prio_search dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush),
    .srch_en(srch_en), .srch_key(srch_key), .matched(matched), .rslt_valid(rslt_valid),
    .hit(hit), .hit_idx(hit_idx), .num_valid(num_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; search expectation uses model contents before this cycle's updates
  task automatic cyc(input logic we, input int wa, input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                     input logic ie, input int ia, input logic fl,
                     input logic se, input logic [DW-1:0] sk);
    rslt_t e;
    @(negedge clk);
    reset = 1; wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_mask = wm;
    inv_en = ie; inv_addr = AW'(ia); flush = fl; srch_en = se; srch_key = sk;
    if (se) begin
      e = '0;
      for (int i = 0; i < DP; i++) e.m[i] = mv[i] && (((sk ^ md[i]) & mm[i]) == '0);
      for (int i = 0; i < DP; i++) if (e.m[i] && !e.h) begin e.h = 1; e.i = AW'(i); end
      exp_q.push_back(e);
    end
    if (fl) mv = '0;
    else begin
      if (ie && ia < DP) mv[ia] = 0;
      if (we && wa < DP) begin mv[wa] = 1; md[wa] = wd; mm[wa] = wm; end
    end
    mcnt = $countones(mv);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic srch(input logic [DW-1:0] k);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, k);
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    reset = 0; wr_en = 0; inv_en = 0; flush = 0; srch_en = 0;
    exp_q.delete();
    mv = '0; mcnt = 0;
    for (int i = 0; i < DP; i++) begin md[i] = '0; mm[i] = '0; end
  endtask

  always @(posedge clk) begin
    rslt_t e;
    #1;
    chk("num_valid", 32'(num_valid), 32'(mcnt));
    if (rslt_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rslt_valid", 32'(rslt_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("matched", 32'(matched), 32'(e.m));
        chk("hit", 32'(hit), 32'(e.h));
        chk("hit_idx", 32'(hit_idx), 32'(e.i));
      end
    end
  end

  initial begin
    for (int i = 0; i < DP; i++) begin md[i] = '0; mm[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_matched", 32'(matched), 0);
    chk("rst_rv", 32'(rslt_valid), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_idx", 32'(hit_idx), 0);
    cyc(1, 4, 8'hD3, 8'h79, 0, 0, 0, 0, 0);
    cyc(1, 5, 8'h69, 8'hC1, 0, 0, 0, 0, 0);
    cyc(1, 6, 8'hF7, 8'hFE, 0, 0, 0, 0, 0);
    srch(8'h55);
    idle(1);
    chk("first_hit_pulse", 32'(rslt_valid), 0);
    idle(1);
    chk("first_matched", 32'(matched), 32'h30);
    chk("first_idx", 32'(hit_idx), 4);
    chk("three_valid", 32'(num_valid), 3);
    srch(8'h85);
    srch(8'hCA);
    idle(2);
    cyc(0, 0, 0, 0, 1, 4, 0, 0, 0);
    srch(8'h55);
    idle(2);
    chk("after_inv_matched", 32'(matched), 32'h20);
    chk("after_inv_idx", 32'(hit_idx), 5);
    cyc(0, 0, 0, 0, 1, 4, 0, 0, 0);
    idle(1);
    chk("double_inv_cnt", 32'(num_valid), 2);
    cyc(1, 0, 8'h55, 8'hFF, 0, 0, 0, 1, 8'h55);
    srch(8'h55);
    idle(1);
    chk("old_contents_idx", 32'(hit_idx), 5);
    idle(1);
    chk("new_contents_matched", 32'(matched), 32'h21);
    chk("new_contents_idx", 32'(hit_idx), 0);
    cyc(1, 7, 8'h00, 8'hFF, 1, 7, 0, 0, 0);
    idle(1);
    chk("wr_inv_same_cnt", 32'(num_valid), 4);
    cyc(1, 9, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    srch(8'h55);
    srch(8'h00);
    idle(2);
    chk("flush_cnt", 32'(num_valid), 0);
    chk("flush_hit", 32'(hit), 0);
    cyc(1, 25, 8'h55, 8'h00, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 31, 0, 1, 8'h55);
    idle(2);
    chk("oob_cnt", 32'(num_valid), 0);
    cyc(1, 3, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    cyc(1, 19, 8'hAA, 8'h0F, 0, 0, 0, 1, 8'h12);
    srch(8'h5A);
    srch(8'h55);
    idle(2);
    chk("dontcare_idx", 32'(hit_idx), 3);
    srch(8'h55);
    rst_cyc();
    idle(1);
    chk("rst_mid_rv", 32'(rslt_valid), 0);
    chk("rst_mid_matched", 32'(matched), 0);
    chk("rst_mid_hit", 32'(hit), 0);
    chk("rst_mid_idx", 32'(hit_idx), 0);
    idle(1);
    chk("rst_mid_rv2", 32'(rslt_valid), 0);
    srch(8'h55);
    idle(3);
    chk("post_rst_hit", 32'(hit), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
